// File: rtl/div_pkg.sv
// Shared definitions for the pipeline stages: divider FSM encodings, widths and
// the level constants used on the start/annul/ready handshake.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

  localparam int         DATA_W     = 32;
  localparam int         RESULT_W   = 64;
  localparam logic [5:0] STEP_COUNT = 6'd32;

  localparam logic READY     = 1'b1;
  localparam logic NOT_READY = 1'b0;
  localparam logic START     = 1'b1;
  localparam logic STOP      = 1'b0;
  localparam logic ANNUL     = 1'b1;
  localparam logic NO_ANNUL  = 1'b0;

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of an operand: only negative values in signed mode are flipped.
  function automatic logic [DATA_W-1:0] magnitude(input logic is_signed,
                                                  input logic [DATA_W-1:0] x);
    return (is_signed && x[DATA_W-1]) ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/div.sv
// Iterative 32-bit restoring divider (signed/unsigned), one quotient bit per cycle,
// with execute-stage start/annul handshake and a registered {remainder, quotient} result.
module div
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [RESULT_W-1:0] result_o,
  output logic                ready_o
);

  div_state_e        state;
  logic [5:0]        cnt;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  logic              neg_quo_q;
  logic              neg_rem_q;

  logic [DATA_W:0]   partial;
  logic [DATA_W+1:0] diff;
  logic              no_borrow;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;
  logic [DATA_W-1:0] quo_final;
  logic [DATA_W-1:0] rem_final;

  // quo_q starts as the dividend magnitude and shifts left each step, feeding its
  // MSB into the partial remainder while the new quotient bit enters at the LSB.
  // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    partial   = {rem_q, quo_q[DATA_W-1]};
    diff      = {1'b0, partial} - {2'b00, dvs_q};
    no_borrow = ~diff[DATA_W+1];
    rem_step  = no_borrow ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
    quo_step  = {quo_q[DATA_W-2:0], no_borrow};
  end

  assign quo_final = neg_quo_q ? neg32(quo_q) : quo_q;
  assign rem_final = neg_rem_q ? neg32(rem_q) : rem_q;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DIV_FREE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          if (start_i == START && annul_i == NO_ANNUL) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= magnitude(signed_div_i, opdata1_i);
            dvs_q     <= magnitude(signed_div_i, opdata2_i);
            neg_quo_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_q <= signed_div_i & opdata1_i[DATA_W-1];
            state     <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          if (annul_i == ANNUL) begin
            state <= DIV_FREE;
          end else begin
            state    <= DIV_END;
            result_o <= '0;
            ready_o  <= READY;
          end
        end
        DIV_ON: begin
          // A flush wins even on the cycle the last step would complete.
          if (annul_i == ANNUL) begin
            state <= DIV_FREE;
          end else if (cnt == STEP_COUNT) begin
            state    <= DIV_END;
            result_o <= {rem_final, quo_final};
            ready_o  <= READY;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt   <= cnt + 6'd1;
          end
        end
        DIV_END: begin
          if (start_i == STOP) begin
            state    <= DIV_FREE;
            result_o <= '0;
            ready_o  <= NOT_READY;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: a latency/arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed results.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: {remainder, quotient}, zero result for a zero divisor.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  // Transaction model: idle -> busy for a fixed latency -> done while start is held.
  typedef enum {M_IDLE, M_BUSY, M_DONE} m_phase_e;
  m_phase_e    m_phase;
  int          m_wait;
  logic [63:0] m_pending;
  logic [63:0] exp_result;
  logic        exp_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase    <= M_IDLE;
      m_wait     <= 0;
      m_pending  <= 64'd0;
      exp_ready  <= 1'b0;
      exp_result <= 64'd0;
    end else begin
      case (m_phase)
        M_IDLE: if (start_i && !annul_i) begin
          m_pending <= ref_div(signed_div_i, opdata1_i, opdata2_i);
          m_wait    <= (opdata2_i == 32'd0) ? 1 : 33;
          m_phase   <= M_BUSY;
        end
        M_BUSY: begin
          if (annul_i) m_phase <= M_IDLE;
          else if (m_wait == 1) begin
            m_phase    <= M_DONE;
            exp_ready  <= 1'b1;
            exp_result <= m_pending;
          end else m_wait <= m_wait - 1;
        end
        M_DONE: if (!start_i) begin
          m_phase    <= M_IDLE;
          exp_ready  <= 1'b0;
          exp_result <= 64'd0;
        end
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    check("cmp_ready", {63'd0, ready_o}, {63'd0, exp_ready});
    check("cmp_result", result_o, exp_result);
  end

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] lit, input int lat);
    int edges;
    edges = -1;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h5A5A_0001;
        signed_div_i = ~sgn;
      end
      if (ready_o) begin
        edges = i;
        break;
      end
    end
    check({name, "_latency"}, 64'(edges), 64'(lat));
    check(name, result_o, lit);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_hold"}, result_o, lit);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_release_ready"}, {63'd0, ready_o}, 64'd0);
    check({name, "_release_result"}, result_o, 64'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b0; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("pin_u100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    check("pin_sm7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    check("pin_smin_m1", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    check("pin_by_zero", ref_div(1'b0, 32'd5, 32'd0), 64'd0);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
    run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34);
    run_div("u5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
    run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
    run_div("u_min_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34);
    run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);

    // Flush at edge 10 of a division: ready must never rise.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk) annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1;
    end
    check("annul_on_no_ready", 64'(seen), 64'd0);
    run_div("u9_3_after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

    // Flush while in the divide-by-zero state.
    @(negedge clk);
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(negedge clk) annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("annul_by_zero_ready", {63'd0, ready_o}, 64'd0);

    // start with annul in FREE must not be accepted.
    @(negedge clk);
    opdata1_i = 32'd8; opdata2_i = 32'd2; start_i = 1'b1; annul_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1;
    end
    check("annul_free_no_accept", 64'(seen), 64'd0);

    // Reset mid-division, then reset while holding a result.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (20) @(posedge clk);
    #3 rst = 1'b1; start_i = 1'b0;
    #1;
    check("rst_mid_on_ready", {63'd0, ready_o}, 64'd0);
    check("rst_mid_on_result", result_o, 64'd0);
    @(negedge clk) rst = 1'b0;

    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        seen = 1;
        break;
      end
    end
    check("pre_rst_end_ready", 64'(seen), 64'd1);
    #2 rst = 1'b1; start_i = 1'b0;
    #1;
    check("rst_in_end_ready", {63'd0, ready_o}, 64'd0);
    check("rst_in_end_result", result_o, 64'd0);
    @(negedge clk) rst = 1'b0;

    run_div("u100_7_after_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

    repeat (2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
